// File: rtl/sag_pkg.sv
// Shared definitions for the sheep-and-goats engines: FSM state codes,
// operation modes and the default operand width.
package sag_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Operation selector carried alongside each request and its result.
  localparam logic MODE_SAG   = 1'b0;
  localparam logic MODE_NRSAG = 1'b1;

  // Engine states, kept as plain two-bit codes so legacy blocks can share them.
  typedef logic [1:0] sagStateT;
  localparam sagStateT IDLE  = 2'd0;
  localparam sagStateT PASS1 = 2'd1;
  localparam sagStateT PASS2 = 2'd2;
  localparam sagStateT DONE  = 2'd3;

endpackage

// File: rtl/sag_serial_step.sv
// Single-bit sheep-and-goats placement: drops one data bit into the result
// at the low pointer (control bit set) or the high pointer (control bit
// clear) and advances that pointer.
module sag_serial_step
  import sag_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] res,
  input  logic             dataBit,
  input  logic             ctlBit,
  input  logic [IDXW-1:0]  j,
  input  logic [IDXW-1:0]  k,
  output logic [WIDTH-1:0] resNext,
  output logic [IDXW-1:0]  jNext,
  output logic [IDXW-1:0]  kNext
);

  // Place the bit and move exactly one of the two pointers toward the other.
  always_comb begin
    // NOTE: every output gets a default before the branch, so no path leaves
    // a value unassigned and no latch can be inferred.
    resNext = res;
    jNext   = j;
    kNext   = k;
    if (ctlBit) begin
      resNext[j] = dataBit;
      jNext      = j + 1'b1;
    end else begin
      resNext[k] = dataBit;
      kNext      = k - 1'b1;
    end
  end

endmodule

// File: rtl/sag_serial.sv
// Bit-serial sheep-and-goats engine. SAG takes WIDTH cycles; NRSAG runs a
// second SAG pass on SAG(di,ci) with the low-popcount mask, 2*WIDTH cycles.
// Valid/ready handshakes on both the request and the result side.
module sag_serial
  import sag_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_di,
  input  logic [WIDTH-1:0] in_ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_do,
  output logic             out_mode,
  output logic             busy
);

  localparam int IDXW = $clog2(WIDTH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  sagStateT         state;
  logic [WIDTH-1:0] diR;
  logic [WIDTH-1:0] ciR;
  logic [WIDTH-1:0] resR;
  logic [IDXW-1:0]  j;
  logic [IDXW-1:0]  k;
  logic [IDXW-1:0]  idx;
  logic [IDXW:0]    popcnt;
  logic             modeR;

  logic [WIDTH-1:0] stepRes;
  logic [IDXW-1:0]  stepJ;
  logic [IDXW-1:0]  stepK;
  logic [IDXW:0]    popNext;
  logic [WIDTH:0]   maskWide;
  logic [WIDTH-1:0] lowMask;
  logic             lastBit;

  // One placement unit serves both passes; the FSM only swaps its operands.
  sag_serial_step #(
    .WIDTH(WIDTH),
    .IDXW (IDXW)
  ) u_step (
    .res    (resR),
    .dataBit(diR[idx]),
    .ctlBit (ciR[idx]),
    .j      (j),
    .k      (k),
    .resNext(stepRes),
    .jNext  (stepJ),
    .kNext  (stepK)
  );

  // Running popcount and the low-popcount mask for the second NRSAG pass.
  // The mask is built one bit wider so popcount==WIDTH gives all ones.
  always_comb begin
    lastBit  = (idx == LAST_IDX);
    popNext  = popcnt + {{IDXW{1'b0}}, ciR[idx]};
    maskWide = ({{WIDTH{1'b0}}, 1'b1} << popNext) - {{WIDTH{1'b0}}, 1'b1};
    lowMask  = maskWide[WIDTH-1:0];
  end

  // Request capture, per-bit placement, pass sequencing and result hold.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: asynchronous reset clears every register, so an aborted
    // operation leaves nothing behind that could later surface as a result.
    if (!resetn) begin
      state  <= IDLE;
      diR    <= '0;
      ciR    <= '0;
      resR   <= '0;
      j      <= '0;
      k      <= '0;
      idx    <= '0;
      popcnt <= '0;
      modeR  <= MODE_SAG;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so later
      // assignments in a branch override earlier ones at the clock edge.
      case (state)
        IDLE: begin
          if (in_valid) begin
            diR    <= in_di;
            ciR    <= in_ci;
            modeR  <= in_mode;
            resR   <= '0;
            j      <= '0;
            k      <= LAST_IDX;
            idx    <= '0;
            popcnt <= '0;
            state  <= PASS1;
          end
        end
        PASS1: begin
          resR   <= stepRes;
          j      <= stepJ;
          k      <= stepK;
          idx    <= idx + 1'b1;
          popcnt <= popNext;
          if (lastBit) begin
            if (modeR == MODE_NRSAG) begin
              diR   <= stepRes;
              ciR   <= lowMask;
              resR  <= '0;
              j     <= '0;
              k     <= LAST_IDX;
              idx   <= '0;
              state <= PASS2;
            end else begin
              state <= DONE;
            end
          end
        end
        PASS2: begin
          resR <= stepRes;
          j    <= stepJ;
          k    <= stepK;
          idx  <= idx + 1'b1;
          if (lastBit) state <= DONE;
        end
        default: begin
          if (out_ready) state <= IDLE;
        end
      endcase
    end
  end

  // Handshake and result outputs decoded from the state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    out_do    = out_valid ? resR : '0;
    out_mode  = out_valid & modeR;
  end

endmodule

// File: tb/tb_sag_serial.sv
// Self-checking bench for sag_serial: directed vectors, backpressure, reset
// mid-pass and randomized requests against a queue-based reference model.
module tb_sag_serial;

  localparam int W = 8;

  logic         clk;
  logic         resetn;
  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [W-1:0] in_di;
  logic [W-1:0] in_ci;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_do;
  logic         out_mode;
  logic         busy;

  int checks = 0;
  int errors = 0;

  sag_serial #(.WIDTH(W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_di    (in_di),
    .in_ci    (in_ci),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_do   (out_do),
    .out_mode (out_mode),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference SAG: bits with control 1 keep order at the bottom, bits with
  // control 0 are stacked from the top down.
  function automatic logic [W-1:0] sagRef(input logic [W-1:0] d, input logic [W-1:0] c);
    logic ones[$];
    logic zeros[$];
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (c[i]) ones.push_back(d[i]);
      else      zeros.push_back(d[i]);
    end
    for (int p = 0; p < ones.size(); p++)  r[p] = ones[p];
    for (int z = 0; z < zeros.size(); z++) r[W-1-z] = zeros[z];
    return r;
  endfunction

  function automatic logic [W-1:0] nrsagRef(input logic [W-1:0] d, input logic [W-1:0] c);
    int pc;
    logic [W-1:0] m;
    pc = $countones(c);
    m  = W'((1 << pc) - 1);
    return sagRef(sagRef(d, c), m);
  endfunction

  task automatic waitReady();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", 32'(in_ready), 32'd1);
  endtask

  // Issue one request, measure latency, check result, optionally hold the
  // result under backpressure (with an optional next request waiting).
  task automatic runOp(input logic [W-1:0] d, input logic [W-1:0] c, input logic m,
                       input int hold, input logic [W-1:0] exp,
                       input logic arm, input logic [W-1:0] nd, input logic [W-1:0] nc,
                       output logic [W-1:0] got);
    int n;
    int lat;
    waitReady();
    in_di    = d;
    in_ci    = c;
    in_mode  = m;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_di    = W'($urandom);
    in_ci    = W'($urandom);
    in_mode  = 1'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    lat = m ? 2 * W : W;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(lat));
    got = out_do;
    check("out_do", 32'(out_do), 32'(exp));
    check("out_mode", 32'(out_mode), 32'(m));
    if (hold > 0) begin
      if (arm) begin
        in_valid = 1'b1;
        in_di    = nd;
        in_ci    = nc;
        in_mode  = 1'b0;
      end
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_do", 32'(out_do), 32'(got));
        check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("valid_drop", 32'(out_valid), 32'd0);
    check("ready_after_done", 32'(in_ready), 32'd1);
  endtask

  logic [W-1:0] r0;
  logic [W-1:0] r1;
  logic [W-1:0] rd;
  logic [W-1:0] rc;
  logic         rm;
  int           stray;

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_di     = '0;
    in_ci     = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_do", 32'(out_do), 32'd0);
    check("rst_out_mode", 32'(out_mode), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    runOp(8'hB2, 8'hF0, 1'b0, 0, 8'h4B, 1'b0, '0, '0, r0);
    runOp(8'hB2, 8'hF0, 1'b1, 0, 8'h2B, 1'b0, '0, '0, r0);
    runOp(8'h01, 8'h00, 1'b0, 0, 8'h80, 1'b0, '0, '0, r0);
    runOp(8'h01, 8'h00, 1'b1, 0, 8'h01, 1'b0, '0, '0, r0);
    runOp(8'hA5, 8'hFF, 1'b0, 0, 8'hA5, 1'b0, '0, '0, r0);
    runOp(8'hA5, 8'hFF, 1'b1, 0, 8'hA5, 1'b0, '0, '0, r0);
    runOp(8'h5C, 8'h80, 1'b0, 0, sagRef(8'h5C, 8'h00), 1'b0, '0, '0, r0);
    runOp(8'h5C, 8'h00, 1'b0, 0, sagRef(8'h5C, 8'h00), 1'b0, '0, '0, r1);
    check("msb_ctl_inert", 32'(r0), 32'(r1));

    // Backpressure for 20 cycles with the next request already waiting;
    // it must be taken only after the result leaves DONE.
    runOp(8'hB2, 8'hF0, 1'b1, 20, 8'h2B, 1'b1, 8'h3C, 8'h0F, r0);
    runOp(8'h3C, 8'h0F, 1'b0, 0, sagRef(8'h3C, 8'h0F), 1'b0, '0, '0, r0);

    // Reset in the middle of the first pass.
    waitReady();
    in_di = 8'hC3; in_ci = 8'h5A; in_mode = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_do", 32'(out_do), 32'd0);
    check("midrst_out_mode", 32'(out_mode), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    stray = 0;
    repeat (2 * W + 4) begin
      @(posedge clk); #1;
      if (out_valid || busy) stray++;
    end
    check("no_stale_result", 32'(stray), 32'd0);
    runOp(8'h96, 8'h3D, 1'b1, 0, nrsagRef(8'h96, 8'h3D), 1'b0, '0, '0, r0);

    // Randomized requests with random backpressure.
    for (int t = 0; t < 300; t++) begin
      rd = W'($urandom);
      rc = W'($urandom);
      rm = 1'($urandom);
      runOp(rd, rc, rm, int'($urandom_range(0, 3)),
            rm ? nrsagRef(rd, rc) : sagRef(rd, rc), 1'b0, '0, '0, r0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
